sc_uart_tx_mmio: RTL and testbench

//  Memory-mapped UART transmitter on the single-cycle core's data-memory bus (downstream of the core's DMem port).

---
 rtl/sc_uart_tx_mmio.sv | 222 ++++++++++++++++++++++
 tb/tb_sc_uart_tx_mmio.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sc_uart_tx_mmio.sv
// sc_uart_tx_mmio: memory-mapped 8N1 UART transmitter on the core data bus.
// A 3-register window (TXDATA, STATUS, CTRL) sits in front of a circular TX FIFO.
// A START/DATA/STOP serializer drains the FIFO. Frames run back to back, with no
// idle gap, while enable is set and bytes are queued.
module sc_uart_tx_mmio #(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_F000,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [31:0] DMemAddress,
  input  logic [31:0] DMemData,
  input  logic [3:0]  DMemByteEn,
  input  logic        DMemWrEn,
  input  logic        DMemRdEn,
  output logic        MmioHit,
  output logic [31:0] MmioRspData,
  output logic        UartTx,
  output logic        TxIrq
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  localparam logic [15:0]   BAUD_RELOAD = 16'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_FULL    = CW'(FIFO_DEPTH);

  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;

  // Address decode. Offsets 0..11 cover three words, so the byte-lane bits
  // need no special handling in the range check.
  logic [31:0] offset;
  logic [1:0]  reg_sel;
  logic        wr_tx, wr_stat_clr, wr_ctrl;

  assign offset  = DMemAddress - BASE_ADDR;
  assign MmioHit = (offset < 32'd12);
  assign reg_sel = offset[3:2];

  assign wr_tx       = MmioHit && DMemWrEn && DMemByteEn[0] && (reg_sel == REG_TXDATA);
  assign wr_stat_clr = MmioHit && DMemWrEn && DMemByteEn[0] && (reg_sel == REG_STATUS)
                       && DMemData[3];
  assign wr_ctrl     = MmioHit && DMemWrEn && DMemByteEn[0] && (reg_sel == REG_CTRL);

  // Store data bits and byte lanes that no register uses.
  logic unused_bus;
  assign unused_bus = ^{DMemData[31:8], DMemData[2:1], DMemByteEn[3:1]};

  // Architectural state.
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          en_q, en_d;
  logic [1:0]    state_q, state_d;
  logic [15:0]   baud_q, baud_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          irq_q, irq_d;

  logic fifo_full, fifo_empty, pop, push;

  assign fifo_full  = (count_q == CNT_FULL);
  assign fifo_empty = (count_q == '0);

  // Serializer: each bit holds the line for CLKS_PER_BIT cycles, and the
  // output register is loaded together with the state change.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (en_q && !fifo_empty) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          state_d = S_START;
          baud_d  = BAUD_RELOAD;
          tx_d    = 1'b0;
        end
      end
      S_START: begin
        if (baud_q == '0) begin
          state_d = S_DATA;
          baud_d  = BAUD_RELOAD;
          idx_d   = 3'd0;
          tx_d    = shift_q[0];
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      S_DATA: begin
        if (baud_q == '0) begin
          baud_d = BAUD_RELOAD;
          if (idx_q == 3'd7) begin
            state_d = S_STOP;
            tx_d    = 1'b1;
          end else begin
            idx_d   = idx_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
          end
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      S_STOP: begin
        if (baud_q == '0) begin
          if (en_q && !fifo_empty) begin
            // Chain straight into the next frame.
            pop     = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            state_d = S_START;
            baud_d  = BAUD_RELOAD;
            tx_d    = 1'b0;
          end else begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  // FIFO bookkeeping. A push into a full FIFO succeeds only when the slot
  // is freed on the same edge; otherwise the byte is dropped and flagged.
  always_comb begin
    push     = wr_tx && (!fifo_full || pop);
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    // A drop on the same edge as a clear leaves the flag set.
    ovf_d = ovf_q;
    if (wr_stat_clr)
      ovf_d = 1'b0;
    if (wr_tx && fifo_full && !pop)
      ovf_d = 1'b1;
    en_d  = wr_ctrl ? DMemData[0] : en_q;
    // Interrupt follows the post-edge state, so it is coherent with STATUS.
    irq_d = (count_d == '0) && (state_d == S_IDLE);
  end

  // FIFO storage has no reset; the pointers and count define its contents.
  always_ff @(posedge Clk) begin
    if (push)
      mem_q[wr_ptr_q] <= DMemData[7:0];
  end

  // Control and serializer registers. Reset aborts any frame and flushes the FIFO.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      en_q     <= 1'b1;
      state_q  <= S_IDLE;
      baud_q   <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      irq_q    <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      en_q     <= en_d;
      state_q  <= state_d;
      baud_q   <= baud_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      irq_q    <= irq_d;
    end
  end

  assign UartTx = tx_q;
  assign TxIrq  = irq_q;

  // Load response, driven only for a load that hits the window.
  logic [31:0] status_word;
  assign status_word = {19'd0, 5'(count_q), 4'd0, ovf_q, (state_q != S_IDLE),
                        fifo_empty, fifo_full};

  always_comb begin
    MmioRspData = 32'd0;
    if (MmioHit && DMemRdEn) begin
      case (reg_sel)
        REG_STATUS: MmioRspData = status_word;
        REG_CTRL:   MmioRspData = {31'd0, en_q};
        default:    MmioRspData = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_sc_uart_tx_mmio.sv
// Bench for sc_uart_tx_mmio. Bus stores feed a byte-queue model. A line
// monitor decodes 8N1 frames, checks bit timing and compares each frame with
// the head of the expected-byte scoreboard.
module tb_sc_uart_tx_mmio;
  localparam int          CPB   = 16;
  localparam int          DEPTH = 8;
  localparam logic [31:0] BASE  = 32'h0000_F000;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic [31:0] DMemAddress = '0;
  logic [31:0] DMemData = '0;
  logic [3:0]  DMemByteEn = '0;
  logic        DMemWrEn = 1'b0;
  logic        DMemRdEn = 1'b0;
  logic        MmioHit;
  logic [31:0] MmioRspData;
  logic        UartTx;
  logic        TxIrq;

  sc_uart_tx_mmio #(.BASE_ADDR(BASE), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .Clk(Clk), .Rst(Rst), .DMemAddress(DMemAddress), .DMemData(DMemData),
    .DMemByteEn(DMemByteEn), .DMemWrEn(DMemWrEn), .DMemRdEn(DMemRdEn),
    .MmioHit(MmioHit), .MmioRspData(MmioRspData), .UartTx(UartTx), .TxIrq(TxIrq));

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: bytes held in the FIFO while disabled, bytes due on the line.
  logic [7:0] pend_q[$];
  logic [7:0] sb_q[$];
  logic       mdl_en = 1'b1;
  logic       mdl_ovf = 1'b0;
  int         starts_q[$];
  int         frames_rx = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] exp_status(input int cnt, input bit busy, input bit ovf);
    return {19'd0, 5'(cnt), 4'd0, ovf, busy, (cnt == 0), (cnt == DEPTH)};
  endfunction

  task automatic model_store(input logic [7:0] b);
    if (mdl_en) sb_q.push_back(b);
    else if (pend_q.size() < DEPTH) pend_q.push_back(b);
    else mdl_ovf = 1'b1;
  endtask

  task automatic model_enable();
    mdl_en = 1'b1;
    while (pend_q.size() > 0) sb_q.push_back(pend_q.pop_front());
  endtask

  // Line monitor: frame is 10*CPB cycles starting at the first low sample.
  logic       m_in = 1'b0;
  int         m_cnt = 0;
  int         m_bit;
  logic       m_bad;
  logic [7:0] m_byte;
  logic [7:0] m_exp;
  always @(negedge Clk) begin
    if (Rst) begin
      m_in = 1'b0;
    end else begin
      if (!m_in && UartTx === 1'b0) begin
        m_in = 1'b1; m_cnt = 0; m_bad = 1'b0; m_byte = '0;
        starts_q.push_back(cyc);
      end else if (m_in) begin
        m_cnt++;
      end
      if (m_in) begin
        m_bit = m_cnt / CPB;
        if (m_bit == 0) begin
          if (UartTx !== 1'b0) m_bad = 1'b1;
        end else if (m_bit <= 8) begin
          if (m_cnt % CPB == 0) m_byte[m_bit-1] = UartTx;
          else if (UartTx !== m_byte[m_bit-1]) m_bad = 1'b1;
        end else if (UartTx !== 1'b1) begin
          m_bad = 1'b1;
        end
        if (m_cnt == 10*CPB - 1) begin
          m_in = 1'b0;
          frames_rx++;
          if (sb_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL unexpected_frame: got byte %02h expected no frame", m_byte);
          end else begin
            m_exp = sb_q.pop_front();
            chk("frame_byte_and_timing", {23'd0, m_bad, m_byte}, {24'd0, m_exp});
          end
        end
      end
    end
  end

  // Bus helpers. wr_now must be entered at a negedge; it returns the edge number sampled.
  logic [31:0] rd_d;
  logic        rd_h;

  task automatic wr_now(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                        output int edge_n);
    edge_n = cyc + 1;
    DMemAddress = a; DMemData = d; DMemByteEn = be; DMemWrEn = 1'b1;
    @(posedge Clk); #1;
    DMemWrEn = 1'b0; DMemByteEn = '0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    int e;
    @(negedge Clk);
    wr_now(a, d, be, e);
  endtask

  task automatic rd(input logic [31:0] a);
    @(negedge Clk);
    DMemAddress = a; DMemRdEn = 1'b1;
    #1;
    rd_d = MmioRspData; rd_h = MmioHit;
    DMemRdEn = 1'b0;
  endtask

  task automatic st_byte(input logic [7:0] b);
    logic [31:0] r;
    r = $urandom();
    model_store(b);
    wr(BASE, {r[31:8], b}, 4'h1);
  endtask

  task automatic wait_done(input int budget, input string name);
    int k;
    k = 0;
    while ((sb_q.size() != 0 || m_in) && k < budget) begin
      @(negedge Clk); k++;
    end
    chk(name, 32'(k < budget), 32'd1);
    repeat (4) @(negedge Clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int e, tgt, nfr, busy_n, irq_lo;
    logic [7:0] b;

    repeat (2) @(posedge Clk);
    #1 Rst = 1'b0;

    // Reset state
    rd(BASE + 4); chk("reset_status", rd_d, exp_status(0, 0, 0));
    chk("reset_uarttx", 32'(UartTx), 32'd1);
    chk("reset_irq", 32'(TxIrq), 32'd1);
    rd(BASE + 8); chk("reset_ctrl", rd_d, 32'd1);

    // Single byte 0xA5: busy for one frame, interrupt low for frame plus the queued cycle
    model_store(8'hA5);
    @(negedge Clk); wr_now(BASE, 32'h0000_00A5, 4'h1, e);
    busy_n = 0; irq_lo = 0;
    for (int i = 0; i < 200; i++) begin
      rd(BASE + 4);
      if (rd_d[2]) busy_n++;
      if (TxIrq === 1'b0) irq_lo++;
    end
    chk("a5_busy_cycles", busy_n, 10*CPB);
    chk("a5_irq_low_cycles", irq_lo, 10*CPB + 1);
    chk("a5_irq_end", 32'(TxIrq), 32'd1);
    wait_done(4*CPB, "a5_drain");

    // Overflow while disabled, then back-to-back drain
    wr(BASE + 8, 32'd0, 4'h1); mdl_en = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) st_byte(8'($urandom()));
    rd(BASE + 4); chk("ovf_status", rd_d, exp_status(pend_q.size(), 0, mdl_ovf));
    starts_q.delete();
    wr(BASE + 8, 32'd1, 4'h1); model_enable();
    wait_done(12*10*CPB, "ovf_drain");
    chk("ovf_frames", starts_q.size(), DEPTH);
    for (int i = 1; i < starts_q.size(); i++)
      chk("no_idle_gap", starts_q[i] - starts_q[i-1], 10*CPB);
    rd(BASE + 4); chk("ovf_before_clear", rd_d, exp_status(0, 0, mdl_ovf));
    wr(BASE + 4, 32'h0000_0008, 4'h1); mdl_ovf = 1'b0;
    rd(BASE + 4); chk("ovf_cleared", rd_d, exp_status(0, 0, 0));

    // Full FIFO, push on the same edge a frame ends and pops
    wr(BASE + 8, 32'd0, 4'h1); mdl_en = 1'b0;
    for (int i = 0; i < DEPTH; i++) st_byte(8'($urandom()));
    @(negedge Clk); wr_now(BASE + 8, 32'd1, 4'h1, e); model_enable();
    st_byte(8'($urandom()));               // sampled on the first-pop edge e+1
    tgt = e + 1 + 10*CPB;                  // edge where the first STOP ends and pops
    while (cyc != tgt - 1) @(negedge Clk);
    b = 8'($urandom()); model_store(b);
    wr_now(BASE, {24'd0, b}, 4'h1, e);
    chk("full_push_edge", e, tgt);
    rd(BASE + 4); chk("full_pop_push_status", rd_d, exp_status(DEPTH, 1, 0));
    wait_done(12*10*CPB, "full_drain");
    rd(BASE + 4); chk("full_drain_status", rd_d, exp_status(0, 0, 0));

    // Clearing enable mid-frame finishes only the current frame
    wr(BASE + 8, 32'd0, 4'h1); mdl_en = 1'b0;
    for (int i = 0; i < 3; i++) st_byte(8'($urandom()));
    wr(BASE + 8, 32'd1, 4'h1);
    sb_q.push_back(pend_q.pop_front());
    repeat (3*CPB) @(negedge Clk);
    wr(BASE + 8, 32'd0, 4'h1);
    wait_done(2*10*CPB, "dis_drain");
    repeat (2*CPB) @(negedge Clk);
    rd(BASE + 4); chk("dis_status", rd_d, exp_status(pend_q.size(), 0, 0));
    chk("dis_irq", 32'(TxIrq), 32'd0);
    wr(BASE + 8, 32'd1, 4'h1); model_enable();
    wait_done(4*10*CPB, "dis_reenable_drain");

    // Randomized bursts, never more than DEPTH outstanding
    for (int r = 0; r < 10; r++) begin
      int n;
      n = $urandom_range(1, DEPTH);
      for (int i = 0; i < n; i++) begin
        st_byte(8'($urandom()));
        repeat ($urandom_range(0, 3)) @(negedge Clk);
      end
      rd(BASE + 8); chk("rand_ctrl", rd_d, 32'd1);
      wait_done((n + 2)*10*CPB, "rand_drain");
      rd(BASE + 4); chk("rand_idle_status", rd_d, exp_status(0, 0, 0));
      chk("rand_irq", 32'(TxIrq), 32'd1);
    end

    // Reset mid-DATA with bytes queued
    wr(BASE + 8, 32'd0, 4'h1); mdl_en = 1'b0;
    for (int i = 0; i < 3; i++) st_byte(8'($urandom()));
    @(negedge Clk); wr_now(BASE + 8, 32'd1, 4'h1, e); model_enable();
    while (cyc < e + 1 + 4*CPB) @(negedge Clk);
    @(posedge Clk); #2 Rst = 1'b1;
    sb_q.delete(); pend_q.delete(); mdl_ovf = 1'b0; mdl_en = 1'b1;
    @(posedge Clk); #1 Rst = 1'b0;
    nfr = frames_rx;
    @(negedge Clk);
    chk("rst_uarttx", 32'(UartTx), 32'd1);
    chk("rst_irq", 32'(TxIrq), 32'd1);
    rd(BASE + 4); chk("rst_status", rd_d, exp_status(0, 0, 0));
    rd(BASE + 8); chk("rst_ctrl", rd_d, 32'd1);
    repeat (40*CPB) @(negedge Clk);
    chk("rst_no_frames", frames_rx, nfr);

    // Outside the window: no hit, zero data, stores ignored
    rd(BASE + 32'hC); chk("oob_hi_hit", 32'(rd_h), 32'd0); chk("oob_hi_data", rd_d, 32'd0);
    rd(BASE - 4);     chk("oob_lo_hit", 32'(rd_h), 32'd0); chk("oob_lo_data", rd_d, 32'd0);
    rd(BASE);         chk("txdata_hit", 32'(rd_h), 32'd1); chk("txdata_read", rd_d, 32'd0);
    rd(BASE + 6);     chk("status_lowbits", rd_d, exp_status(0, 0, 0));
    wr(BASE + 32'hC, 32'h0000_0055, 4'hF);
    wr(BASE - 4, 32'h0000_0055, 4'hF);
    wr(BASE + 8, 32'd0, 4'h0);             // no byte-0 enable: CTRL unchanged
    nfr = frames_rx;
    repeat (12*CPB) @(negedge Clk);
    chk("oob_no_frames", frames_rx, nfr);
    rd(BASE + 4); chk("oob_status", rd_d, exp_status(0, 0, 0));
    rd(BASE + 8); chk("ctrl_be0_ignored", rd_d, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
